// File: rtl/unsigned_div_16by8_seq.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per cycle,
// valid/ready handshakes on both sides. Define UDIV_DZ_FLAG_EN for the divide-by-zero flag and fast path.
module unsigned_div_16by8_seq #(
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] z,
    input  logic [DW-1:0]   y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] q,
    output logic [DW-1:0]   r
`ifdef UDIV_DZ_FLAG_EN
    ,
    output logic            dz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(2*DW-1);

    state_t            state_r;
    state_t            state_next_s;
    logic [2*DW-1:0]   dividend_r;
    logic [DW-1:0]     divisor_r;
    logic [DW-1:0]     part_r;
    logic [2*DW-1:0]   quot_r;
    logic [CW-1:0]     cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [DW:0]       shifted_s;
    logic              ge_s;
    logic [DW-1:0]     rem_next_s;
`ifdef UDIV_DZ_FLAG_EN
    logic              dz_r;
`endif

    // One restoring step: the shifted partial is DW+1 bits, but after the step it always fits in DW
    // (it is < y, or with y=0 its top bit is shifted out on the next step anyway).
    always_comb begin
        shifted_s  = {part_r, dividend_r[2*DW-1]};
        ge_s       = (shifted_s >= {1'b0, divisor_r});
        rem_next_s = shifted_s[DW-1:0];
        if (ge_s) begin
            rem_next_s = DW'(shifted_s - {1'b0, divisor_r});
        end else begin
            rem_next_s = shifted_s[DW-1:0];
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
`ifdef UDIV_DZ_FLAG_EN
                    if (y == {DW{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = BUSY;
                    end
`else
                    state_next_s = BUSY;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == LAST_ITER) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Datapath: operand capture, iteration, and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_r <= {(2*DW){1'b0}};
            divisor_r  <= {DW{1'b0}};
            part_r     <= {DW{1'b0}};
            quot_r     <= {(2*DW){1'b0}};
            cnt_r      <= {CW{1'b0}};
`ifdef UDIV_DZ_FLAG_EN
            dz_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        dividend_r <= z;
                        divisor_r  <= y;
                        part_r     <= {DW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
`ifdef UDIV_DZ_FLAG_EN
                        if (y == {DW{1'b0}}) begin
                            quot_r <= {(2*DW){1'b1}};
                            dz_r   <= 1'b1;
                        end else begin
                            quot_r <= {(2*DW){1'b0}};
                            dz_r   <= 1'b0;
                        end
`else
                        quot_r     <= {(2*DW){1'b0}};
`endif
                    end
                end
                BUSY: begin
                    dividend_r <= {dividend_r[2*DW-2:0], 1'b0};
                    part_r     <= rem_next_s;
                    quot_r     <= {quot_r[2*DW-2:0], ge_s};
                    cnt_r      <= cnt_r + CW'(1);
                end
                DONE: begin
`ifdef UDIV_DZ_FLAG_EN
                    if (out_ready) begin
                        dz_r <= 1'b0;
                    end
`endif
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign q         = quot_r;
    assign r         = part_r;
`ifdef UDIV_DZ_FLAG_EN
    assign dz        = dz_r;
`endif

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench for unsigned_div_16by8_seq: directed cases plus a randomized sweep,
// compared every cycle against a plain-arithmetic model of the divider's observable behaviour.
module tb_unsigned_div_16by8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state
    bit          pending = 1'b0;
    bit          exp_ov;
    int          ready_cyc = 0;
    int          lat;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          acc_cnt = 0;
    int          acc_cyc_q[$];

    unsigned_div_16by8_seq #(.DW(8), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r)
`ifdef UDIV_DZ_FLAG_EN
        ,
        .dz        (dz)
`endif
    );

`ifndef UDIV_DZ_FLAG_EN
    assign dz = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Expected result from plain arithmetic; lat = edges from accept to out_valid.
    function automatic void model(input logic [15:0] zv, input logic [7:0] yv,
                                  output logic [15:0] mq, output logic [7:0] mr,
                                  output logic mdz, output int mlat);
        if (yv == 8'd0) begin
            mq = 16'hFFFF;
`ifdef UDIV_DZ_FLAG_EN
            mr = 8'h00; mdz = 1'b1; mlat = 1;
`else
            mr = zv[7:0]; mdz = 1'b0; mlat = 16;
`endif
        end else begin
            mq = zv / {8'd0, yv};
            mr = 8'(zv % {8'd0, yv});
            mdz = 1'b0; mlat = 16;
        end
    endfunction

    // Compare process: checks outputs each negedge, then advances the model for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_ov = pending && (cyc >= ready_cyc);
                chk("in_ready", 32'(in_ready), 32'(!pending));
                chk("out_valid", 32'(out_valid), 32'(exp_ov));
                if (exp_ov) begin
                    chk("q", 32'(q), 32'(eq));
                    chk("r", 32'(r), 32'(er));
                    chk("dz", 32'(dz), 32'(edz));
                end
                if (rst) begin
                    pending = 1'b0;
                end else if (exp_ov && out_ready) begin
                    pending = 1'b0;
                end else if (!pending && in_valid) begin
                    model(z, y, eq, er, edz, lat);
                    ready_cyc = cyc + 1 + lat;
                    pending = 1'b1;
                    acc_cyc_q.push_back(cyc);
                    acc_cnt++;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] zv, input logic [7:0] yv, input bit keep);
        int n;
        int k;
        n = acc_cnt;
        in_valid = 1'b1; z = zv; y = yv;
        k = 0;
        while (acc_cnt == n && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (acc_cnt == n) chk("accept_timeout", 32'(0), 32'(1));
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_result(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'(1));
    endtask

    task automatic handshake(input int stall);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] zv;
        logic [7:0]  yv;
        logic [15:0] q_hold;
        logic [7:0]  r_hold;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = 16'd0; y = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_r", 32'(r), 32'(0));
        chk("rst_dz", 32'(dz), 32'(0));
        chk_en = 1'b1;

        // basic divide with latency and hold
        issue(16'd50000, 8'd7, 1'b0);
        wait_result(k);
        chk("lat_basic", 32'(k), 32'(16));
        chk("q_50000_7", 32'(q), 32'(7142));
        chk("r_50000_7", 32'(r), 32'(6));
        q_hold = q; r_hold = r;
        repeat (5) begin @(posedge clk); #1; end
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_q", 32'(q), 32'(7142));
        chk("hold_r", 32'(r), 32'(6));
        handshake(0);
        chk("idle_after_hs", 32'(in_ready), 32'(1));

        // reset mid-BUSY at iteration 7
        issue(16'hFFFF, 8'h01, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_q", 32'(q), 32'(0));
        chk("midrst_r", 32'(r), 32'(0));
        repeat (20) begin @(posedge clk); #1; end

        // divisor extremes and zero dividend
        issue(16'hFFFF, 8'hFF, 1'b0); wait_result(k);
        chk("q_ffff_ff", 32'(q), 32'(257)); chk("r_ffff_ff", 32'(r), 32'(0));
        handshake(1);
        issue(16'hFFFF, 8'h01, 1'b0); wait_result(k);
        chk("q_ffff_01", 32'(q), 32'(16'hFFFF)); chk("r_ffff_01", 32'(r), 32'(0));
        handshake(0);
        issue(16'h0000, 8'h80, 1'b0); wait_result(k);
        chk("q_0_80", 32'(q), 32'(0)); chk("r_0_80", 32'(r), 32'(0));
        handshake(2);

        // divide by zero
        issue(16'h1234, 8'h00, 1'b0); wait_result(k);
        chk("q_dz", 32'(q), 32'(16'hFFFF));
`ifdef UDIV_DZ_FLAG_EN
        chk("lat_dz", 32'(k), 32'(1));
        chk("r_dz", 32'(r), 32'(0));
        chk("dz_flag", 32'(dz), 32'(1));
`else
        chk("lat_dz", 32'(k), 32'(16));
        chk("r_dz", 32'(r), 32'(8'h34));
`endif
        handshake(0);
        chk("dz_cleared", 32'(dz), 32'(0));

        // back-to-back with in_valid and out_ready held high
        begin
            int n0;
            n0 = acc_cnt;
            out_ready = 1'b1;
            issue(16'd1000, 8'd3, 1'b1);
            issue(16'd65000, 8'd250, 1'b1);
            issue(16'd12345, 8'd99, 1'b0);
            wait_result(k);
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (acc_cyc_q.size() >= n0 + 3) begin
                chk("b2b_gap1", 32'(acc_cyc_q[n0+1] - acc_cyc_q[n0]), 32'(18));
                chk("b2b_gap2", 32'(acc_cyc_q[n0+2] - acc_cyc_q[n0+1]), 32'(18));
            end else begin
                chk("b2b_accepts", 32'(acc_cyc_q.size() - n0), 32'(3));
            end
        end

        // random sweep with stalls and idle gaps
        for (int i = 0; i < 2000; i++) begin
            zv = 16'($urandom);
            yv = 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(zv, yv, 1'b0);
            wait_result(k);
            chk("prop_qyr", 32'(q) * 32'(yv) + 32'(r), 32'(zv));
            chk("prop_r_lt_y", 32'(r < yv), 32'(1));
            handshake($urandom_range(0, 3));
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
